// File: rtl/mem_access_unit.sv
// Load/store unit between the control FSM and the memory port (XLEN 32/64, sub-word access, timeout).
// Optional macro MAU_MISALIGN_TRAP_EN: misaligned requests complete at once with an error instead of being rounded down.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [XLEN-1:0]   mem_address,
  output logic [XLEN/8-1:0] mem_byte_enable,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int SHW  = $clog2(XLEN);
  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = (TIMEOUT > 0) ? CNTW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e          state_q;
  logic [1:0]      size_q;
  logic            unsigned_q;
  logic [OFFW-1:0] off_q;
  logic [CNTW-1:0] cnt_q;
  logic            mem_read_q, mem_write_q;
  logic [XLEN-1:0] mem_address_q, mem_wdata_q;
  logic [NB-1:0]   mem_be_q;
  logic            rsp_valid_q, rsp_err_q;
  logic [XLEN-1:0] rsp_rdata_q;

  logic [1:0]      req_size_log2;
  logic [OFFW-1:0] req_off, req_off_eff, size_mask;
  logic            req_illegal;
  logic [NB-1:0]   req_be;
  logic [XLEN-1:0] lane_mask, req_wdata_lane;

  // Request decode: size, effective lane offset, legality, lane mask and lane-shifted store data.
  always_comb begin
    req_size_log2 = req_funct3[1:0];
    size_mask     = OFFW'((1 << req_size_log2) - 1);
    req_off       = req_addr[OFFW-1:0];
    req_illegal   = (req_funct3 == 3'b111) ||
                    ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
`ifdef MAU_MISALIGN_TRAP_EN
    req_off_eff   = req_off;
    req_illegal   = req_illegal || ((req_off & size_mask) != '0);
`else
    req_off_eff   = req_off & ~size_mask;
`endif
    req_be        = NB'(((1 << (1 << req_size_log2)) - 1) << req_off_eff);
    lane_mask     = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[8*i +: 8] = {8{req_be[i]}};
    end
    req_wdata_lane = (req_wdata << {req_off_eff, 3'b000}) & lane_mask;
  end

  logic [XLEN-1:0] rd_shifted, rd_keep, ld_data_d;
  logic [SHW-1:0]  rd_top;
  logic            rd_sign;

  // Load data: bring the addressed lanes down to bit 0, truncate to size, then extend.
  always_comb begin
    rd_shifted = mem_rdata >> {off_q, 3'b000};
    rd_keep    = (XLEN'(1) << (8 << size_q)) - XLEN'(1);
    rd_top     = SHW'((8 << size_q) - 1);
    rd_sign    = ~unsigned_q & rd_shifted[rd_top];
    ld_data_d  = (rd_shifted & rd_keep) | ({XLEN{rd_sign}} & ~rd_keep);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      off_q         <= '0;
      cnt_q         <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            size_q     <= req_size_log2;
            unsigned_q <= req_funct3[2];
            off_q      <= req_off_eff;
            cnt_q      <= '0;
            if (req_illegal) begin
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q       <= S_ACCESS;
              mem_read_q    <= ~req_write;
              mem_write_q   <= req_write;
              mem_address_q <= {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
              mem_be_q      <= req_be;
              mem_wdata_q   <= req_write ? req_wdata_lane : '0;
            end
          end
        end
        S_ACCESS: begin
          // A response arriving on the last budgeted cycle still beats the timeout.
          if (mem_resp) begin
            state_q     <= S_DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= mem_write_q ? '0 : ld_data_d;
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            state_q     <= S_DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNTW'(1);
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = mem_address_q;
  assign mem_byte_enable = mem_be_q;
  assign mem_wdata       = mem_wdata_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_rdata       = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: one XLEN=32/TIMEOUT=4 and one XLEN=64/TIMEOUT=0 instance against a transaction-level model.
// Follows MAU_MISALIGN_TRAP_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic v32, wr32, resp32, rdy32, rv32, err32, mr32, mw32;
  logic [2:0] f32;
  logic [31:0] a32, wd32, mrd32, rd32, ma32, mwd32;
  logic [3:0] be32;

  logic v64, wr64, resp64, rdy64, rv64, err64, mr64, mw64;
  logic [2:0] f64;
  logic [63:0] a64, wd64, mrd64, rd64, ma64, mwd64;
  logic [7:0] be64;

  mem_access_unit #(.XLEN(32), .TIMEOUT(4)) u32 (
    .clk(clk), .rst(rst), .req_valid(v32), .req_ready(rdy32), .req_write(wr32),
    .req_funct3(f32), .req_addr(a32), .req_wdata(wd32), .rsp_valid(rv32), .rsp_rdata(rd32),
    .rsp_err(err32), .mem_read(mr32), .mem_write(mw32), .mem_address(ma32),
    .mem_byte_enable(be32), .mem_wdata(mwd32), .mem_rdata(mrd32), .mem_resp(resp32));

  mem_access_unit #(.XLEN(64), .TIMEOUT(0)) u64 (
    .clk(clk), .rst(rst), .req_valid(v64), .req_ready(rdy64), .req_write(wr64),
    .req_funct3(f64), .req_addr(a64), .req_wdata(wd64), .rsp_valid(rv64), .rsp_rdata(rd64),
    .rsp_err(err64), .mem_read(mr64), .mem_write(mw64), .mem_address(ma64),
    .mem_byte_enable(be64), .mem_wdata(mwd64), .mem_rdata(mrd64), .mem_resp(resp64));

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: expected outputs for the coming cycle, derived from the access rules.
  bit armed = 1'b0;
  logic eRdy[2], eRd[2], eWr[2], eRv[2], eErr[2];
  logic [63:0] eAddr[2], eBe[2], eWd[2], eRdata[2];
  int spent[2], mOff[2], mSize[2];
  bit mSgn[2];

  function automatic logic [63:0] loadValue(input logic [63:0] raw, input int off, input int size,
                                            input bit sgn, input int xl);
    logic [127:0] v, lim;
    v   = 128'(raw) >> (8 * off);
    lim = 128'(1) << (8 * size);
    v   = v % lim;
    if (sgn && v >= (lim >> 1)) v = v - lim;
    return 64'(v % (128'(1) << xl));
  endfunction

  task automatic modelAccept(input int d, input bit wr, input logic [2:0] f3,
                             input logic [63:0] addr, input logic [63:0] wd);
    int xl, nb, size, off;
    bit bad;
    logic [127:0] w;
    xl   = (d != 0) ? 64 : 32;
    nb   = xl / 8;
    size = 1 << f3[1:0];
    off  = int'(addr % 64'(nb));
    bad  = (f3 == 3'd7) || (xl == 32 && (f3 == 3'd3 || f3 == 3'd6));
`ifdef MAU_MISALIGN_TRAP_EN
    if (off % size != 0) bad = 1'b1;
`else
    off = off - (off % size);
`endif
    eRdy[d] = 1'b0;
    if (bad) begin
      eRv[d] = 1'b1; eErr[d] = 1'b1; eRdata[d] = '0;
    end else begin
      eRd[d]   = !wr;
      eWr[d]   = wr;
      spent[d] = 0;
      eAddr[d] = addr - (addr % 64'(nb));
      eBe[d]   = ((64'd1 << size) - 64'd1) << off;
      w        = (128'(wd) % (128'(1) << (8 * size))) << (8 * off);
      eWd[d]   = 64'(w);
      mOff[d]  = off;
      mSize[d] = size;
      mSgn[d]  = !f3[2];
    end
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic rv, wr, mresp;
      logic [2:0] f3;
      logic [63:0] a, wd, mrd;
      int to, xl;
      if (d == 0) begin
        rv = v32; wr = wr32; mresp = resp32; f3 = f32; a = 64'(a32); wd = 64'(wd32); mrd = 64'(mrd32);
      end else begin
        rv = v64; wr = wr64; mresp = resp64; f3 = f64; a = a64; wd = wd64; mrd = mrd64;
      end
      to = (d == 0) ? 4 : 0;
      xl = (d == 0) ? 32 : 64;
      if (rst) begin
        armed = 1'b1;
        eRdy[d] = 1'b1; eRd[d] = 1'b0; eWr[d] = 1'b0; eRv[d] = 1'b0; eErr[d] = 1'b0;
        eAddr[d] = '0; eBe[d] = '0; eWd[d] = '0; eRdata[d] = '0; spent[d] = 0;
      end else if (armed) begin
        if (eRv[d]) begin
          eRv[d] = 1'b0; eErr[d] = 1'b0; eRdy[d] = 1'b1;
        end else if (eRd[d] || eWr[d]) begin
          spent[d]++;
          if (mresp) begin
            eRv[d] = 1'b1; eErr[d] = 1'b0;
            eRdata[d] = eWr[d] ? 64'd0 : loadValue(mrd, mOff[d], mSize[d], mSgn[d], xl);
            eRd[d] = 1'b0; eWr[d] = 1'b0;
          end else if (to != 0 && spent[d] == to) begin
            eRv[d] = 1'b1; eErr[d] = 1'b1; eRdata[d] = '0;
            eRd[d] = 1'b0; eWr[d] = 1'b0;
          end
        end else if (rv) begin
          modelAccept(d, wr, f3, a, wd);
        end
      end
    end
  end

  // Compare every cycle, half a period after the active edge.
  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        logic aRdy, aRd, aWr, aRv, aErr;
        logic [63:0] aAddr, aBe, aWd, aRdata;
        string p;
        if (d == 0) begin
          aRdy = rdy32; aRd = mr32; aWr = mw32; aRv = rv32; aErr = err32;
          aAddr = 64'(ma32); aBe = 64'(be32); aWd = 64'(mwd32); aRdata = 64'(rd32);
        end else begin
          aRdy = rdy64; aRd = mr64; aWr = mw64; aRv = rv64; aErr = err64;
          aAddr = ma64; aBe = 64'(be64); aWd = mwd64; aRdata = rd64;
        end
        p = (d == 0) ? "x32" : "x64";
        checkOutput({p, " req_ready"}, 64'(aRdy), 64'(eRdy[d]));
        checkOutput({p, " mem_read"}, 64'(aRd), 64'(eRd[d]));
        checkOutput({p, " mem_write"}, 64'(aWr), 64'(eWr[d]));
        checkOutput({p, " rsp_valid"}, 64'(aRv), 64'(eRv[d]));
        if (eRd[d] || eWr[d]) begin
          checkOutput({p, " mem_address"}, aAddr, eAddr[d]);
          checkOutput({p, " mem_byte_enable"}, aBe, eBe[d]);
        end
        if (eWr[d]) checkOutput({p, " mem_wdata"}, aWd, eWd[d]);
        if (eRv[d]) begin
          checkOutput({p, " rsp_err"}, 64'(aErr), 64'(eErr[d]));
          checkOutput({p, " rsp_rdata"}, aRdata, eRdata[d]);
        end
      end
    end
  end

  // Per-cycle history of one transaction, cycle 0 being the accept cycle.
  logic hStb[12], hWr[12], hRdy[12], hRv[12], hErr[12];
  logic [63:0] hAddr[12], hBe[12], hWd[12], hRd[12];

  task automatic drive(input int d, input bit v, input bit wr, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input bit resp, input logic [63:0] rd);
    if (d == 0) begin
      v32 = v; wr32 = wr; f32 = f3; a32 = a[31:0]; wd32 = wd[31:0]; resp32 = resp; mrd32 = rd[31:0];
    end else begin
      v64 = v; wr64 = wr; f64 = f3; a64 = a; wd64 = wd; resp64 = resp; mrd64 = rd;
    end
  endtask

  task automatic sample(input int d, input int c);
    if (d == 0) begin
      hStb[c] = mr32 | mw32; hWr[c] = mw32; hRdy[c] = rdy32; hRv[c] = rv32; hErr[c] = err32;
      hAddr[c] = 64'(ma32); hBe[c] = 64'(be32); hWd[c] = 64'(mwd32); hRd[c] = 64'(rd32);
    end else begin
      hStb[c] = mr64 | mw64; hWr[c] = mw64; hRdy[c] = rdy64; hRv[c] = rv64; hErr[c] = err64;
      hAddr[c] = ma64; hBe[c] = 64'(be64); hWd[c] = mwd64; hRd[c] = rd64;
    end
  endtask

  task automatic applyStimulus(input int d, input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                               input logic [63:0] wd, input logic [63:0] rdata, input int respAt,
                               input int validCycles, input int rstAt);
    @(posedge clk); #2;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(posedge clk); #2;
      end
      rst = (c == rstAt);
      drive(d, c < validCycles, wr, f3, addr, wd, (c > 0) && (c == respAt), rdata);
      @(negedge clk);
      sample(d, c);
    end
  endtask

  // Strobe expected exactly in cycles first..last, rsp_valid only in cycle rspC (none if negative).
  task automatic checkTimeline(input string name, input int first, input int last, input int rspC);
    for (int c = 0; c < 12; c++) begin
      checkOutput({name, " strobe"}, 64'(hStb[c]), 64'((c >= first) && (c <= last)));
      checkOutput({name, " rsp_valid"}, 64'(hRv[c]), 64'(c == rspC));
    end
    if (rspC >= 0 && rspC + 1 < 12) begin
      checkOutput({name, " ready low"}, 64'(hRdy[rspC]), 64'd0);
      checkOutput({name, " ready back"}, 64'(hRdy[rspC + 1]), 64'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 3'd0, '0, '0, 0, '0);
    drive(1, 0, 0, 3'd0, '0, '0, 0, '0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checkOutput("reset ready", 64'(rdy32), 64'd1);
    checkOutput("reset strobes", {62'd0, mr32, mw32}, 64'd0);
    checkOutput("reset rsp", {31'd0, rv32, err32, rd32}, 64'd0);
    checkOutput("reset mem x32", {ma32, 4'd0, be32, mwd32[23:0]}, 64'd0);
    checkOutput("reset mem x64", ma64 | mwd64 | 64'(be64) | rd64 | 64'({mr64, mw64, rv64, err64}), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    applyStimulus(0, 0, 3'b000, 64'h1003, 64'h0, 64'h80FF_0000, 1, 1, -1);
    checkTimeline("lb", 1, 1, 2);
    checkOutput("lb addr", hAddr[1], 64'h1000);
    checkOutput("lb be", hBe[1], 64'h8);
    checkOutput("lb rdata", hRd[2], 64'hFFFF_FF80);
    checkOutput("lb err", 64'(hErr[2]), 64'd0);

    applyStimulus(0, 1, 3'b001, 64'h2002, 64'h1234_ABCD, 64'h0, 2, 1, -1);
    checkTimeline("sh", 1, 2, 3);
    checkOutput("sh write", 64'(hWr[1]), 64'd1);
    checkOutput("sh be", hBe[1], 64'hC);
    checkOutput("sh wdata", hWd[2], 64'hABCD_0000);
    checkOutput("sh rdata", hRd[3], 64'd0);

    applyStimulus(0, 0, 3'b010, 64'h40, 64'h0, 64'hDEAD_BEEF, 0, 1, -1);
    checkTimeline("lw timeout", 1, 4, 5);
    checkOutput("lw timeout err", 64'(hErr[5]), 64'd1);
    checkOutput("lw timeout rdata", hRd[5], 64'd0);

    applyStimulus(0, 0, 3'b010, 64'h40, 64'h0, 64'hDEAD_BEEF, 4, 1, -1);
    checkTimeline("lw late resp", 1, 4, 5);
    checkOutput("lw late err", 64'(hErr[5]), 64'd0);
    checkOutput("lw late rdata", hRd[5], 64'hDEAD_BEEF);

    applyStimulus(0, 0, 3'b011, 64'h0, 64'h0, 64'h1, 2, 1, -1);
    checkTimeline("ld on x32", 1, 0, 1);
    checkOutput("ld on x32 err", 64'(hErr[1]), 64'd1);

    applyStimulus(0, 1, 3'b111, 64'h8, 64'h55, 64'h0, 1, 1, -1);
    checkTimeline("funct3 111", 1, 0, 1);
    checkOutput("funct3 111 err", 64'(hErr[1]), 64'd1);

    applyStimulus(0, 0, 3'b010, 64'h1001, 64'h0, 64'h1122_3344, 1, 1, -1);
`ifdef MAU_MISALIGN_TRAP_EN
    checkTimeline("lw misaligned", 1, 0, 1);
    checkOutput("lw misaligned err", 64'(hErr[1]), 64'd1);
`else
    checkTimeline("lw misaligned", 1, 1, 2);
    checkOutput("lw misaligned addr", hAddr[1], 64'h1000);
    checkOutput("lw misaligned be", hBe[1], 64'hF);
    checkOutput("lw misaligned err", 64'(hErr[2]), 64'd0);
`endif

    applyStimulus(0, 0, 3'b101, 64'h6, 64'h0, 64'h8001_0000, 1, 3, -1);
    checkTimeline("lhu held valid", 1, 1, 2);
    checkOutput("lhu rdata", hRd[2], 64'h0000_8001);

    applyStimulus(0, 0, 3'b001, 64'h2, 64'h0, 64'h9ABC_0000, 3, 1, -1);
    checkTimeline("lh", 1, 3, 4);
    checkOutput("lh rdata", hRd[4], 64'hFFFF_9ABC);

    applyStimulus(0, 1, 3'b000, 64'h3001, 64'hFFFF_FF5A, 64'h0, 1, 1, -1);
    checkTimeline("sb", 1, 1, 2);
    checkOutput("sb be", hBe[1], 64'h2);
    checkOutput("sb wdata", hWd[1], 64'h0000_5A00);

    applyStimulus(0, 1, 3'b001, 64'h2003, 64'h0000_BEEF, 64'h0, 1, 1, -1);

    applyStimulus(0, 0, 3'b010, 64'h50, 64'h0, 64'h0, 0, 1, 2);
    checkTimeline("rst mid access", 1, 2, -1);
    checkOutput("rst ready", 64'(hRdy[3]), 64'd1);

    applyStimulus(1, 0, 3'b110, 64'h0C, 64'h0, 64'hF000_0001_0000_0000, 3, 1, -1);
    checkTimeline("lwu x64", 1, 3, 4);
    checkOutput("lwu addr", hAddr[1], 64'h8);
    checkOutput("lwu be", hBe[1], 64'hF0);
    checkOutput("lwu rdata", hRd[4], 64'h0000_0000_F000_0001);

    applyStimulus(1, 0, 3'b011, 64'h8, 64'h0, 64'h8000_0000_0000_0001, 1, 1, -1);
    checkTimeline("ld x64", 1, 1, 2);
    checkOutput("ld be", hBe[1], 64'hFF);
    checkOutput("ld rdata", hRd[2], 64'h8000_0000_0000_0001);

    applyStimulus(1, 0, 3'b010, 64'h4, 64'h0, 64'h8000_0000_1234_5678, 2, 1, -1);
    checkTimeline("lw x64", 1, 2, 3);
    checkOutput("lw x64 rdata", hRd[3], 64'hFFFF_FFFF_8000_0000);

    applyStimulus(1, 1, 3'b011, 64'h10, 64'h1122_3344_5566_7788, 64'h0, 1, 1, -1);
    checkTimeline("sd x64", 1, 1, 2);
    checkOutput("sd wdata", hWd[1], 64'h1122_3344_5566_7788);
    checkOutput("sd be", hBe[1], 64'hFF);

    applyStimulus(1, 0, 3'b111, 64'h0, 64'h0, 64'h0, 1, 1, -1);
    checkTimeline("funct3 111 x64", 1, 0, 1);

    applyStimulus(1, 0, 3'b000, 64'h7, 64'h0, 64'h7F00_0000_0000_0000, 9, 1, -1);
    checkTimeline("no timeout x64", 1, 9, 10);
    checkOutput("lb x64 rdata", hRd[10], 64'h7F);
    checkOutput("lb x64 err", 64'(hErr[10]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
